// File: rtl/pipeline_control_unit_if.sv
// Bundle between the hazard unit / pipeline datapath and the pipeline control
// unit.
//   master : hazard-unit side. Drives the stall, flush, branch and hold requests
//            and observes the PC, enables, clears, valid bits and counters.
//   slave  : pipeline_control_unit side.
// Signal summary:
//   stall, flush1..flush5, branchTakenFlag, branchTarget[31:0], hold  -> control
//   pc[31:0], regEn[4:0], regClr[4:0], valid[4:0],
//   stallCount, flushCount, retiredCount [COUNT_W-1:0], stall_timeout <- control
interface pipeline_control_unit_if #(
  parameter int COUNT_W = 16
);
  logic               stall;
  logic               flush1;
  logic               flush2;
  logic               flush3;
  logic               flush4;
  logic               flush5;
  logic               branchTakenFlag;
  logic [31:0]        branchTarget;
  logic               hold;

  logic [31:0]        pc;
  logic [4:0]         regEn;
  logic [4:0]         regClr;
  logic [4:0]         valid;
  logic [COUNT_W-1:0] stallCount;
  logic [COUNT_W-1:0] flushCount;
  logic [COUNT_W-1:0] retiredCount;
  logic               stall_timeout;

  modport master (
    output stall, flush1, flush2, flush3, flush4, flush5,
           branchTakenFlag, branchTarget, hold,
    input  pc, regEn, regClr, valid,
           stallCount, flushCount, retiredCount, stall_timeout
  );

  modport slave (
    input  stall, flush1, flush2, flush3, flush4, flush5,
           branchTakenFlag, branchTarget, hold,
    output pc, regEn, regClr, valid,
           stallCount, flushCount, retiredCount, stall_timeout
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: turns hazard-unit requests into per-register load
// enables and bubble clears for the five pipeline registers (1=PC/IF, 2=IF/ID,
// 3=ID/EX, 4=EX/MEM, 5=MEM/WB), owns the PC and branch redirect, tracks a valid
// bit per register, keeps saturating stall/flush/retire counters and raises a
// sticky watchdog when a load-use stall runs for MAX_STALL cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : pipeline_control_unit_if.slave (requests in, control/status out)
module pipeline_control_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          COUNT_W   = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_control_unit_if.slave        bus
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  logic [4:0]         flushVec;
  logic               stallEff;
  logic [4:0]         regEn;
  logic [4:0]         regClr;

  logic [31:0]        pcReg;
  logic [4:0]         validReg;
  logic [COUNT_W-1:0] stallCountReg;
  logic [COUNT_W-1:0] flushCountReg;
  logic [COUNT_W-1:0] retiredCountReg;
  logic [RUN_W-1:0]   stallRun;
  logic               timeoutReg;

  assign flushVec = {bus.flush5, bus.flush4, bus.flush3, bus.flush2, bus.flush1};

  // A taken branch squashes the younger instructions, so the load-use stall
  // they caused no longer matters.
  assign stallEff = bus.stall & ~bus.branchTakenFlag;

  always_comb begin
    // NOTE: defaults first so every path assigns both vectors and no latch is inferred.
    regEn  = '0;
    regClr = '0;
    if (!bus.hold) begin
      regEn     = {3'b111, ~stallEff, ~stallEff};
      regClr    = flushVec;
      // Stalled instruction stays in ID; a bubble goes into ID/EX instead.
      regClr[2] = flushVec[2] | stallEff;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours (the valid shift depends on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg           <= RESET_PC;
      validReg        <= '0;
      stallCountReg   <= '0;
      flushCountReg   <= '0;
      retiredCountReg <= '0;
      stallRun        <= '0;
      timeoutReg      <= 1'b0;
    end else if (!bus.hold) begin
      // Redirect wins over the stall; otherwise advance unless stalled.
      if (bus.branchTakenFlag) begin
        pcReg <= bus.branchTarget;
      end else if (!stallEff) begin
        pcReg <= pcReg + 32'd4;
      end

      // Stage 1 refills with a fresh fetch unless stalled; later stages shift
      // the upstream valid bit in. Clear beats enable.
      validReg[0] <= flushVec[0] ? 1'b0 : (stallEff ? validReg[0] : 1'b1);
      for (int i = 1; i < 5; i++) begin
        validReg[i] <= regClr[i] ? 1'b0 : (regEn[i] ? validReg[i-1] : validReg[i]);
      end

      if (stallEff && (stallCountReg != '1)) begin
        stallCountReg <= stallCountReg + 1'b1;
      end
      if (bus.branchTakenFlag && (flushCountReg != '1)) begin
        flushCountReg <= flushCountReg + 1'b1;
      end
      if (validReg[4] && (retiredCountReg != '1)) begin
        retiredCountReg <= retiredCountReg + 1'b1;
      end

      // Consecutive-stall run length. A stall masked by a redirect neither
      // extends nor breaks the run; dropping stall breaks it. The run counter
      // parks at MAX_STALL since the flag is already sticky by then.
      if (!bus.stall) begin
        stallRun <= '0;
      end else if (stallEff && (stallRun != RUN_W'(MAX_STALL))) begin
        stallRun <= stallRun + 1'b1;
      end
      if (stallEff && (stallRun == RUN_W'(MAX_STALL - 1))) begin
        timeoutReg <= 1'b1;
      end
    end
  end

  assign bus.pc            = pcReg;
  assign bus.regEn         = regEn;
  assign bus.regClr        = regClr;
  assign bus.valid         = validReg;
  assign bus.stallCount    = stallCountReg;
  assign bus.flushCount    = flushCountReg;
  assign bus.retiredCount  = retiredCountReg;
  assign bus.stall_timeout = timeoutReg;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit. Counters are built 4 bits wide so
// saturation is reachable within the watchdog scenario.
module tb_pipeline_control_unit;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared = 0;
  int   nMismatch = 0;

  always #5 clk = ~clk;

  pipeline_control_unit_if #(.COUNT_W(CW)) bus ();

  pipeline_control_unit #(
    .RESET_PC (32'h0000_0000),
    .COUNT_W  (CW),
    .MAX_STALL(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.flush1          = 1'b0;
    bus.flush2          = 1'b0;
    bus.flush3          = 1'b0;
    bus.flush4          = 1'b0;
    bus.flush5          = 1'b0;
    bus.branchTakenFlag = 1'b0;
    bus.branchTarget    = 32'h0;
    bus.hold            = 1'b0;
  endtask

  // Reset, then five free edges: pc=20, valid=11111, all counters 0.
  task automatic reset_fill();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    nCompared++;
    if (bus.pc !== 32'h0) begin
      nMismatch++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0);
    end
    nCompared++;
    if (bus.valid !== 5'b00000) begin
      nMismatch++; $display("FAIL reset_valid got=%b exp=%b", bus.valid, 5'b00000);
    end
    nCompared++;
    if ({bus.stallCount, bus.flushCount, bus.retiredCount} !== '0) begin
      nMismatch++; $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0",
                            bus.stallCount, bus.flushCount, bus.retiredCount);
    end
    nCompared++;
    if (bus.stall_timeout !== 1'b0) begin
      nMismatch++; $display("FAIL reset_timeout got=%b exp=0", bus.stall_timeout);
    end
  endtask

  task automatic test_fill();
    logic [4:0] expValid [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};
    clear_inputs();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nCompared++;
      if (bus.pc !== 32'(4 * i)) begin
        nMismatch++; $display("FAIL fill_pc[%0d] got=%h exp=%h", i, bus.pc, 32'(4 * i));
      end
      tick();
      nCompared++;
      if (bus.valid !== expValid[i]) begin
        nMismatch++; $display("FAIL fill_valid[%0d] got=%b exp=%b", i, bus.valid, expValid[i]);
      end
    end
    nCompared++;
    if (bus.retiredCount !== 4'd1) begin
      nMismatch++; $display("FAIL fill_retired got=%0d exp=1", bus.retiredCount);
    end
  endtask

  task automatic test_stall();
    reset_fill();
    bus.stall = 1'b1;
    #1;
    nCompared++;
    if (bus.regEn !== 5'b11100) begin
      nMismatch++; $display("FAIL stall_regEn got=%b exp=%b", bus.regEn, 5'b11100);
    end
    nCompared++;
    if (bus.regClr !== 5'b00100) begin
      nMismatch++; $display("FAIL stall_regClr got=%b exp=%b", bus.regClr, 5'b00100);
    end
    tick();
    bus.stall = 1'b0;
    nCompared++;
    if (bus.pc !== 32'd20) begin
      nMismatch++; $display("FAIL stall_pc_hold got=%h exp=%h", bus.pc, 32'd20);
    end
    nCompared++;
    if (bus.valid !== 5'b11011) begin
      nMismatch++; $display("FAIL stall_valid got=%b exp=%b", bus.valid, 5'b11011);
    end
    nCompared++;
    if (bus.stallCount !== 4'd1) begin
      nMismatch++; $display("FAIL stall_count got=%0d exp=1", bus.stallCount);
    end
    tick();
    nCompared++;
    if (bus.valid !== 5'b10111 || bus.pc !== 32'd24) begin
      nMismatch++; $display("FAIL stall_resume got=%b/%h exp=%b/%h", bus.valid, bus.pc, 5'b10111, 32'd24);
    end
    nCompared++;
    if (bus.retiredCount !== 4'd2) begin
      nMismatch++; $display("FAIL stall_retired got=%0d exp=2", bus.retiredCount);
    end
  endtask

  task automatic test_branch();
    reset_fill();
    bus.branchTakenFlag = 1'b1;
    bus.branchTarget    = 32'h40;
    bus.flush2          = 1'b1;
    bus.flush3          = 1'b1;
    bus.flush4          = 1'b1;
    #1;
    nCompared++;
    if (bus.regClr !== 5'b01110 || bus.regEn !== 5'b11111) begin
      nMismatch++; $display("FAIL branch_ctrl got=%b/%b exp=%b/%b", bus.regClr, bus.regEn, 5'b01110, 5'b11111);
    end
    tick();
    clear_inputs();
    nCompared++;
    if (bus.pc !== 32'h40) begin
      nMismatch++; $display("FAIL branch_pc got=%h exp=%h", bus.pc, 32'h40);
    end
    nCompared++;
    if (bus.valid !== 5'b10001) begin
      nMismatch++; $display("FAIL branch_valid got=%b exp=%b", bus.valid, 5'b10001);
    end
    nCompared++;
    if (bus.flushCount !== 4'd1) begin
      nMismatch++; $display("FAIL branch_flushCount got=%0d exp=1", bus.flushCount);
    end
  endtask

  task automatic test_stall_branch();
    reset_fill();
    bus.stall           = 1'b1;
    bus.branchTakenFlag = 1'b1;
    bus.branchTarget    = 32'h80;
    #1;
    nCompared++;
    if (bus.regEn[1:0] !== 2'b11 || bus.regClr !== 5'b00000) begin
      nMismatch++; $display("FAIL stallbr_ctrl got=%b/%b exp=%b/%b", bus.regEn, bus.regClr, 5'b11111, 5'b00000);
    end
    tick();
    clear_inputs();
    nCompared++;
    if (bus.pc !== 32'h80) begin
      nMismatch++; $display("FAIL stallbr_pc got=%h exp=%h", bus.pc, 32'h80);
    end
    nCompared++;
    if (bus.stallCount !== 4'd0 || bus.flushCount !== 4'd1) begin
      nMismatch++; $display("FAIL stallbr_counts got=%0d/%0d exp=0/1", bus.stallCount, bus.flushCount);
    end
  endtask

  task automatic test_hold();
    reset_fill();
    bus.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.stall           = (c != 1);
      bus.branchTakenFlag = (c == 1);
      bus.branchTarget    = 32'h100;
      {bus.flush5, bus.flush4, bus.flush3, bus.flush2, bus.flush1} = (c == 1) ? 5'b11111 : 5'b00000;
      #1;
      nCompared++;
      if (bus.regEn !== 5'b00000 || bus.regClr !== 5'b00000) begin
        nMismatch++; $display("FAIL hold_ctrl[%0d] got=%b/%b exp=00000/00000", c, bus.regEn, bus.regClr);
      end
      tick();
    end
    nCompared++;
    if (bus.pc !== 32'd20 || bus.valid !== 5'b11111) begin
      nMismatch++; $display("FAIL hold_frozen got=%h/%b exp=%h/%b", bus.pc, bus.valid, 32'd20, 5'b11111);
    end
    nCompared++;
    if ({bus.stallCount, bus.flushCount, bus.retiredCount} !== '0) begin
      nMismatch++; $display("FAIL hold_counters got=%0d/%0d/%0d exp=0/0/0",
                            bus.stallCount, bus.flushCount, bus.retiredCount);
    end
    clear_inputs();
    tick();
    nCompared++;
    if (bus.pc !== 32'd24 || bus.retiredCount !== 4'd1) begin
      nMismatch++; $display("FAIL hold_release got=%h/%0d exp=%h/1", bus.pc, bus.retiredCount, 32'd24);
    end
  endtask

  task automatic test_watchdog();
    reset_fill();
    for (int run = 0; run < 2; run++) begin
      bus.stall = 1'b1;
      repeat (7) tick();
      nCompared++;
      if (bus.stall_timeout !== 1'b0) begin
        nMismatch++; $display("FAIL wd_short_run[%0d] got=%b exp=0", run, bus.stall_timeout);
      end
      nCompared++;
      if (bus.stallCount !== 4'(7 * (run + 1))) begin
        nMismatch++; $display("FAIL wd_stallCount[%0d] got=%0d exp=%0d", run, bus.stallCount, 7 * (run + 1));
      end
      bus.stall = 1'b0;
      tick();
    end
    bus.stall = 1'b1;
    repeat (7) tick();
    nCompared++;
    if (bus.stall_timeout !== 1'b0) begin
      nMismatch++; $display("FAIL wd_edge7 got=%b exp=0", bus.stall_timeout);
    end
    tick();
    nCompared++;
    if (bus.stall_timeout !== 1'b1) begin
      nMismatch++; $display("FAIL wd_edge8 got=%b exp=1", bus.stall_timeout);
    end
    bus.stall = 1'b0;
    tick();
    nCompared++;
    if (bus.stall_timeout !== 1'b1) begin
      nMismatch++; $display("FAIL wd_sticky got=%b exp=1", bus.stall_timeout);
    end
    nCompared++;
    if (bus.stallCount !== 4'hF) begin
      nMismatch++; $display("FAIL wd_saturate got=%0d exp=15", bus.stallCount);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nCompared++;
    if (bus.stall_timeout !== 1'b0 || bus.pc !== 32'h0 || bus.valid !== 5'b00000) begin
      nMismatch++; $display("FAIL wd_reset got=%b/%h/%b exp=0/%h/%b", bus.stall_timeout, bus.pc, bus.valid, 32'h0, 5'b00000);
    end
    nCompared++;
    if (bus.stallCount !== 4'd0) begin
      nMismatch++; $display("FAIL wd_reset_count got=%0d exp=0", bus.stallCount);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_branch();
    test_stall_branch();
    test_hold();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
